multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Next-generation control for the RV32I core: a multi-cycle FSM replacing the single-cycle combinational decoder.
- Sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK over one shared memory port, with a ready handshake for variable-latency memory.
- Decodes the full branch set and flags illegal opcodes.
- Sits between instruction register/flag inputs and the datapath muxes, PC, register file and memory interface.

Parameters:
- ALU_CTRL_W, 3, width of alu_control.
- FULL_BRANCH, 1, 1: BEQ/BNE/BLT/BGE/BLTU/BGEU decoded; 0: every B-type treated as BNE.
- MEM_TIMEOUT, 15, maximum cycles waiting for mem_ready before entering TRAP; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- op  in  7  instruction[6:0], valid from DECODE onward
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- zero  in  1  ALU result == 0
- lt  in  1  signed rs1 < rs2
- ltu  in  1  unsigned rs1 < rs2
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request valid
- mem_write  out  1  request is a write
- mem_src  out  3  access size/sign (funct3 for data; 3'b010 for fetch)
- adr_src  out  1  0: PC, 1: ALUOut
- ir_write  out  1  load instruction register
- pc_write  out  1  load PC from result bus
- alu_src_a  out  2  0: PC, 1: oldPC, 2: rs1
- alu_src_b  out  2  0: rs2, 1: imm, 2: constant 4
- alu_control  out  ALU_CTRL_W  0 add, 1 sub, 2 pass-B (LUI)
- imm_src  out  3  0 I, 1 B, 2 S, 3 J, 4 U
- result_src  out  2  0: ALUOut, 1: memory data, 2: ALU result
- reg_write  out  1  register file write enable
- trap  out  1  sticky; set on illegal opcode or timeout
- state  out  4  current state, for debug

Behaviour:
- Async reset: state=FETCH, wait counter=0, trap=0. All write/request outputs are Moore-decoded from state and are 0 during reset.
- States: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, LUI=12, TRAP=15.
- FETCH:
  - mem_req=1, adr_src=0, mem_src=3'b010.
  - On mem_ready: ir_write=1, pc_write=1 (a=PC, b=4, result_src=2), go to DECODE. Otherwise hold.
- DECODE: a=oldPC, b=imm (B/J), add; target is captured in ALUOut. Next state by op:
  - 0000011 → MEMADR
  - 0100011 → MEMADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 → LUI
  - any other op → TRAP
- MEMADR: a=rs1, b=imm (I for loads, S for stores), add. Go to MEMRD for loads, MEMWR for stores.
- MEMRD: mem_req=1, adr_src=1, mem_src=funct3. On mem_ready go to MEMWB.
- MEMWB: result_src=1, reg_write=1, then FETCH.
- MEMWR: mem_req=1, mem_write=1, adr_src=1, mem_src=funct3. On mem_ready go to FETCH.
- EXEC_R: a=rs1, b=rs2. alu_control=1 if funct7==0100000, else 0. Then ALUWB.
- EXEC_I: a=rs1, b=imm, add. Then ALUWB.
- ALUWB: result_src=0, reg_write=1, then FETCH.
- BRANCH: a=rs1, b=rs2, sub.
  - Taken is decoded from funct3: 000 zero, 001 !zero, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
  - With FULL_BRANCH=0, taken = !zero.
  - If taken: pc_write=1, result_src=0 (target in ALUOut). Then FETCH.
- JAL:
  - Cycle 1: a=oldPC, b=4, result_src=2, reg_write=1; pc_write=1 with result_src=0 is deferred.
  - Implementation: JAL writes rd=PC+4 in its first cycle, and PC=ALUOut in the same cycle on a separate PC path. pc_write and reg_write are both 1; the PC mux takes ALUOut via adr-independent result_src=0 for PC. The datapath provides PC<-ALUOut when pc_write and state==JAL/BRANCH/JALR.
  - Then FETCH.
- JALR:
  - Cycle 1: a=rs1, b=imm, add, pc_write=1 with result_src=2, reg_write=1 using rd=oldPC+4.
  - The datapath captures oldPC+4 before the PC update.
  - Then FETCH.
- LUI: b=imm(U), alu_control=2, result_src=2, reg_write=1, then FETCH.
- Timeout: the wait counter increments each cycle mem_req=1 && !mem_ready, and clears on mem_ready or on a state change. When the count reaches MEM_TIMEOUT (≠0), go to TRAP.
- TRAP:
  - trap=1, all enables 0; the FSM stays in TRAP until reset.
  - The trap bit is also sticky across further cycles.
- mem_ready arriving in the same cycle as the timeout reaches its limit: completion wins.
- Reset asserted mid-access: immediate return to FETCH; the pending access is abandoned and no write enable glitches high.
- mem_ready outside the memory states is ignored.

Test Plan:
- ADDI with mem_ready tied 1 → states 0,1,7,8,0. reg_write is high only in ALUWB; 4 cycles total.
- LW with mem_ready delayed 3 cycles in MEMRD → MEMRD held for 4 cycles, then MEMWB with result_src=1; mem_src=010 throughout MEMRD.
- BLT with lt=1, then BGE with lt=1 (FULL_BRANCH=1) → pc_write=1 in BRANCH for the first only. With FULL_BRANCH=0 and zero=0, both are taken.
- op=0001111 → DECODE→TRAP; trap=1 sticky, no writes for 20 cycles; rst_n low clears it.
- mem_ready held 0 in FETCH, MEM_TIMEOUT=15 → TRAP after 15 waiting cycles. mem_ready rising on the 15th cycle instead → DECODE, no trap.
- rst_n low during MEMWR with mem_ready=0 → state=0 asynchronously; mem_write=0 and mem_req=0 until the next FETCH cycle.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM. It sequences fetch, decode, execute, memory and
// writeback over one shared memory port, and traps on illegal opcodes or memory timeout.
module multicycle_control_unit #(
  parameter int ALU_CTRL_W  = 3,
  parameter bit FULL_BRANCH = 1'b1,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic [2:0]            mem_src,
  output logic                  adr_src,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [2:0]            imm_src,
  output logic [1:0]            result_src,
  output logic                  reg_write,
  output logic                  trap,
  output logic [3:0]            state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC_R = 4'd6,
    S_EXEC_I = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9,
    S_JAL    = 4'd10,
    S_JALR   = 4'd11,
    S_LUI    = 4'd12,
    S_TRAP   = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      wait_q, wait_d;
  logic                  trap_q, trap_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_write_q, mem_write_d;
  logic [2:0]            mem_src_q, mem_src_d;
  logic                  adr_src_q, adr_src_d;
  logic [1:0]            alu_src_a_q, alu_src_a_d;
  logic [1:0]            alu_src_b_q, alu_src_b_d;
  logic [ALU_CTRL_W-1:0] alu_control_q, alu_control_d;
  logic [1:0]            result_src_q, result_src_d;
  logic                  reg_write_q, reg_write_d;
  logic                  pc_write_q, pc_write_d;
  logic                  mem_fire;
  logic                  taken;

  // A request only completes while it is actually being presented.
  assign mem_fire = mem_req_q & mem_ready;

  always_comb begin
    taken = 1'b0;
    if (!FULL_BRANCH) begin
      taken = !zero;
    end else begin
      case (funct3)
        3'b000:  taken = zero;
        3'b001:  taken = !zero;
        3'b100:  taken = lt;
        3'b101:  taken = !lt;
        3'b110:  taken = ltu;
        3'b111:  taken = !ltu;
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_fire) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_R:              state_d = S_EXEC_R;
          OP_I:              state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: state_d = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_fire) state_d = S_MEMWB;
      S_MEMWR:  if (mem_fire) state_d = S_FETCH;
      S_EXEC_R, S_EXEC_I: state_d = S_ALUWB;
      S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI: state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_TRAP;
    endcase
    // Completion in the final waiting cycle wins over the timeout.
    if ((MEM_TIMEOUT != 0) && mem_req_q && !mem_ready && (wait_q == WAIT_LAST))
      state_d = S_TRAP;
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || mem_fire)
      wait_d = '0;
    else if (mem_req_q && !mem_ready)
      wait_d = wait_q + 1'b1;
    trap_d = trap_q | (state_d == S_TRAP);
  end

  // Moore outputs are decoded from the next state so they register in step with it.
  always_comb begin
    mem_req_d     = 1'b0;
    mem_write_d   = 1'b0;
    mem_src_d     = 3'b010;
    adr_src_d     = 1'b0;
    alu_src_a_d   = 2'd0;
    alu_src_b_d   = 2'd0;
    alu_control_d = '0;
    result_src_d  = 2'd0;
    reg_write_d   = 1'b0;
    pc_write_d    = 1'b0;
    case (state_d)
      S_FETCH: begin
        mem_req_d    = 1'b1;
        alu_src_b_d  = 2'd2;
        result_src_d = 2'd2;
      end
      S_DECODE: begin
        alu_src_a_d = 2'd1;
        alu_src_b_d = 2'd1;
      end
      S_MEMADR: begin
        alu_src_a_d = 2'd2;
        alu_src_b_d = 2'd1;
      end
      S_MEMRD: begin
        mem_req_d = 1'b1;
        adr_src_d = 1'b1;
        mem_src_d = funct3;
      end
      S_MEMWB: begin
        result_src_d = 2'd1;
        reg_write_d  = 1'b1;
      end
      S_MEMWR: begin
        mem_req_d   = 1'b1;
        mem_write_d = 1'b1;
        adr_src_d   = 1'b1;
        mem_src_d   = funct3;
      end
      S_EXEC_R: begin
        alu_src_a_d   = 2'd2;
        alu_control_d = (funct7 == 7'b0100000) ? ALU_CTRL_W'(1) : '0;
      end
      S_EXEC_I: begin
        alu_src_a_d = 2'd2;
        alu_src_b_d = 2'd1;
      end
      S_ALUWB:  reg_write_d = 1'b1;
      S_BRANCH: begin
        alu_src_a_d   = 2'd2;
        alu_control_d = ALU_CTRL_W'(1);
      end
      S_JAL: begin
        alu_src_a_d  = 2'd1;
        alu_src_b_d  = 2'd2;
        result_src_d = 2'd2;
        reg_write_d  = 1'b1;
        pc_write_d   = 1'b1;
      end
      S_JALR: begin
        alu_src_a_d  = 2'd2;
        alu_src_b_d  = 2'd1;
        result_src_d = 2'd2;
        reg_write_d  = 1'b1;
        pc_write_d   = 1'b1;
      end
      S_LUI: begin
        alu_src_b_d   = 2'd1;
        alu_control_d = ALU_CTRL_W'(2);
        result_src_d  = 2'd2;
        reg_write_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      trap_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_src_q     <= 3'b010;
      adr_src_q     <= 1'b0;
      alu_src_a_q   <= 2'd0;
      alu_src_b_q   <= 2'd0;
      alu_control_q <= '0;
      result_src_q  <= 2'd0;
      reg_write_q   <= 1'b0;
      pc_write_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      trap_q        <= trap_d;
      mem_req_q     <= mem_req_d;
      mem_write_q   <= mem_write_d;
      mem_src_q     <= mem_src_d;
      adr_src_q     <= adr_src_d;
      alu_src_a_q   <= alu_src_a_d;
      alu_src_b_q   <= alu_src_b_d;
      alu_control_q <= alu_control_d;
      result_src_q  <= result_src_d;
      reg_write_q   <= reg_write_d;
      pc_write_q    <= pc_write_d;
    end
  end

  // The immediate format follows the instruction register, which only settles in DECODE.
  always_comb begin
    imm_src = 3'd0;
    case (state_q)
      S_DECODE: imm_src = (op == OP_JAL) ? 3'd3 : 3'd1;
      S_MEMADR: imm_src = (op == OP_STORE) ? 3'd2 : 3'd0;
      S_BRANCH: imm_src = 3'd1;
      S_LUI:    imm_src = 3'd4;
      default:  imm_src = 3'd0;
    endcase
  end

  assign ir_write    = (state_q == S_FETCH) & mem_fire;
  assign pc_write    = pc_write_q | ir_write | ((state_q == S_BRANCH) & taken);
  assign mem_req     = mem_req_q;
  assign mem_write   = mem_write_q;
  assign mem_src     = mem_src_q;
  assign adr_src     = adr_src_q;
  assign alu_src_a   = alu_src_a_q;
  assign alu_src_b   = alu_src_b_q;
  assign alu_control = alu_control_q;
  assign result_src  = result_src_q;
  assign reg_write   = reg_write_q;
  assign trap        = trap_q;
  assign state       = state_q;

endmodule
